// File: rtl/sim_jtag.sv
// sim_jtag: on-chip replacement for a remote-bitbang JTAG host.
//
// Bit-bang commands are queued in a small FIFO and replayed onto the JTAG
// pins one command per tick (one tick every TICK_DELAY clock cycles while
// running). TDO is sampled on every applied pin command. An exit command
// freezes the driver and publishes {exit_code, 1'b1} on `exit`.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   enable, init_done       both high (and no exit yet) => ticks run
//   cmd_valid/cmd_ready     command handshake
//   cmd_data[3:0]           {TCK, TMS, TDI, TRSTn} pin command
//   cmd_exit, cmd_exit_code exit command flag and 31-bit code
//   jtag_TCK/TMS/TDI/TRSTn  registered JTAG pin outputs
//   jtag_TDO_data/_driven   TDO from the target and its drive indication
//   tdo_valid, tdo_bit      one-cycle pulse + sampled TDO per pin command
//   exit[31:0]              0 while running, {code, 1'b1} after exit
module sim_jtag #(
    parameter int TICK_DELAY = 50,
    parameter int PORT       = 4567,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        init_done,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_data,
    input  logic        cmd_exit,
    input  logic [30:0] cmd_exit_code,
    output logic        jtag_TCK,
    output logic        jtag_TMS,
    output logic        jtag_TDI,
    output logic        jtag_TRSTn,
    input  logic        jtag_TDO_data,
    input  logic        jtag_TDO_driven,
    output logic        tdo_valid,
    output logic        tdo_bit,
    output logic [31:0] exit
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = (TICK_DELAY > 1) ? $clog2(TICK_DELAY) : 1;
    localparam int ENT_W = 36;

    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(TICK_DELAY - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    // PORT is only an identifier for the harness; it has no function here.
    // Illegal parameter combinations leave this block populated as a marker.
    if (TICK_DELAY < 1 || FIFO_DEPTH < 2 || PORT < 0) begin : g_bad_params
    end

    // FIFO entry layout: {is_exit, exit_code[30:0], pins[3:0]}
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [3:0]       pins_q,   pins_d;
    logic             tdo_valid_q, tdo_valid_d;
    logic             tdo_bit_q,   tdo_bit_d;
    logic [31:0]      exit_q,   exit_d;

    logic             exited;
    logic             run;
    logic             tick;
    logic             ready;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    always_comb begin
        // exit_q[0] is set by every exit command, so it alone marks "exited".
        exited = exit_q[0];
        run    = enable && init_done && !exited;
        tick   = run && (cnt_q == '0);
        ready  = (count_q != FULL_CNT) && !exited;
        push   = cmd_valid && ready;
        // Pop is decided on the pre-push count, so a same-cycle push is
        // never bypassed to the pins.
        pop    = tick && (count_q != '0);
        head   = mem_q[rd_ptr_q];

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pins_d      = pins_q;
        tdo_valid_d = 1'b0;
        tdo_bit_d   = tdo_bit_q;
        exit_d      = exit_q;

        if (!run || tick) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (head[ENT_W-1]) begin
                exit_d = {head[ENT_W-2:4], 1'b1};
            end else begin
                pins_d      = head[3:0];
                // TDO is taken in the tick cycle, before the new pins apply.
                tdo_bit_d   = jtag_TDO_driven ? jtag_TDO_data : 1'b0;
                tdo_valid_d = 1'b1;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cnt_q       <= RELOAD;
            pins_q      <= 4'b0001;
            tdo_valid_q <= 1'b0;
            tdo_bit_q   <= 1'b0;
            exit_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            pins_q      <= pins_d;
            tdo_valid_q <= tdo_valid_d;
            tdo_bit_q   <= tdo_bit_d;
            exit_q      <= exit_d;
        end
    end

    // Storage needs no reset: only entries counted by count_q are ever read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_exit, cmd_exit_code, cmd_data};
        end
    end

    assign cmd_ready  = ready;
    assign jtag_TCK   = pins_q[3];
    assign jtag_TMS   = pins_q[2];
    assign jtag_TDI   = pins_q[1];
    assign jtag_TRSTn = pins_q[0];
    assign tdo_valid  = tdo_valid_q;
    assign tdo_bit    = tdo_bit_q;
    assign exit       = exit_q;

endmodule

// File: tb/tb_sim_jtag.sv
// Self-checking bench for sim_jtag (TICK_DELAY=4, FIFO_DEPTH=4).
module tb_sim_jtag;

    localparam int TD    = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        init_done = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_data = 4'h0;
    logic        cmd_exit = 1'b0;
    logic [30:0] cmd_exit_code = '0;
    logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
    logic        jtag_TDO_data = 1'b0;
    logic        jtag_TDO_driven = 1'b0;
    logic        tdo_valid;
    logic        tdo_bit;
    logic [31:0] exit;

    sim_jtag #(.TICK_DELAY(TD), .PORT(4567), .FIFO_DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .init_done      (init_done),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_data       (cmd_data),
        .cmd_exit       (cmd_exit),
        .cmd_exit_code  (cmd_exit_code),
        .jtag_TCK       (jtag_TCK),
        .jtag_TMS       (jtag_TMS),
        .jtag_TDI       (jtag_TDI),
        .jtag_TRSTn     (jtag_TRSTn),
        .jtag_TDO_data  (jtag_TDO_data),
        .jtag_TDO_driven(jtag_TDO_driven),
        .tdo_valid      (tdo_valid),
        .tdo_bit        (tdo_bit),
        .exit           (exit)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Queue of {is_exit, code, pins}; ticks happen on every TD-th consecutive
    // run cycle (run-streak index TD-1, 2*TD-1, ...).
    logic [35:0] mq[$];
    logic [31:0] m_exit;
    logic [3:0]  m_pins;
    logic        m_tv, m_tb;
    int          m_streak;

    function automatic logic m_ready();
        return (mq.size() < DEPTH) && (m_exit == 0);
    endfunction

    task automatic model_edge();
        logic run, tick, rdy;
        logic [35:0] e;
        if (reset) begin
            mq.delete();
            m_exit = 0; m_pins = 4'b0001; m_tv = 0; m_tb = 0; m_streak = 0;
        end else begin
            run  = enable && init_done && (m_exit == 0);
            rdy  = m_ready();
            tick = run && ((m_streak % TD) == TD - 1);
            m_streak = run ? m_streak + 1 : 0;
            m_tv = 0;
            if (tick && mq.size() > 0) begin
                e = mq.pop_front();
                if (e[35]) m_exit = {e[34:4], 1'b1};
                else begin
                    m_pins = e[3:0];
                    m_tb   = jtag_TDO_driven ? jtag_TDO_data : 1'b0;
                    m_tv   = 1;
                end
            end
            if (cmd_valid && rdy) mq.push_back({cmd_exit, cmd_exit_code, cmd_data});
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return 64'({cmd_ready, jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, tdo_valid, tdo_bit, exit});
    endfunction

    function automatic logic [63:0] mdl_vec();
        return 64'({m_ready(), m_pins, m_tv, m_tb, m_exit});
    endfunction

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        chk("model", dut_vec(), mdl_vec());
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic ex, input logic [30:0] code);
        cmd_valid = v; cmd_data = d; cmd_exit = ex; cmd_exit_code = code;
    endtask

    task automatic do_reset();
        reset = 1; drive(0, 4'h0, 0, '0);
        cyc(); cyc();
        reset = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        en, init, valid;
        logic [3:0]  data;
        logic        ex;
        logic [30:0] code;
        logic        tdo_d, tdo_drv;
        logic        e_ready;
        logic [3:0]  e_pins;
        logic        e_tv, e_tb;
        logic [31:0] e_exit;
    } vec_t;

    function automatic vec_t row(logic v, logic [3:0] d, logic ex, logic [30:0] code,
                                 logic td, logic tdrv, logic er, logic [3:0] ep,
                                 logic etv, logic etb, logic [31:0] eex);
        vec_t r;
        r.en = 1; r.init = 1; r.valid = v; r.data = d; r.ex = ex; r.code = code;
        r.tdo_d = td; r.tdo_drv = tdrv;
        r.e_ready = er; r.e_pins = ep; r.e_tv = etv; r.e_tb = etb; r.e_exit = eex;
        return r;
    endfunction

    vec_t tbl[16];

    initial begin
        logic [3:0] bp_cmds [4];
        int k, pulses, first;

        tbl[0]  = row(1, 4'b1011, 0, 0, 0, 0, 1, 4'b0001, 0, 0, 0);
        tbl[1]  = row(0, 4'b0000, 0, 0, 1, 1, 1, 4'b0001, 0, 0, 0);
        tbl[2]  = row(0, 4'b0000, 0, 0, 1, 1, 1, 4'b0001, 0, 0, 0);
        tbl[3]  = row(0, 4'b0000, 0, 0, 1, 1, 1, 4'b1011, 1, 1, 0);
        tbl[4]  = row(1, 4'b0110, 0, 0, 1, 0, 1, 4'b1011, 0, 1, 0);
        tbl[5]  = row(0, 4'b0000, 0, 0, 1, 0, 1, 4'b1011, 0, 1, 0);
        tbl[6]  = row(0, 4'b0000, 0, 0, 1, 0, 1, 4'b1011, 0, 1, 0);
        tbl[7]  = row(0, 4'b0000, 0, 0, 1, 0, 1, 4'b0110, 1, 0, 0);
        tbl[8]  = row(1, 4'b0000, 1, 5, 0, 0, 1, 4'b0110, 0, 0, 0);
        tbl[9]  = row(0, 4'b0000, 0, 0, 0, 0, 1, 4'b0110, 0, 0, 0);
        tbl[10] = row(0, 4'b0000, 0, 0, 0, 0, 1, 4'b0110, 0, 0, 0);
        tbl[11] = row(0, 4'b0000, 0, 0, 0, 0, 0, 4'b0110, 0, 0, 32'd11);
        for (int i = 12; i < 16; i++)
            tbl[i] = row(1, 4'b1111, 0, 0, 1, 1, 0, 4'b0110, 0, 0, 32'd11);

        // ---- reset state ----
        do_reset();
        chk("reset_state", dut_vec(), 64'({1'b1, 4'b0001, 1'b0, 1'b0, 32'd0}));

        // ---- table: first tick, TDO sampling, exit ----
        for (int i = 0; i < 16; i++) begin
            enable = tbl[i].en; init_done = tbl[i].init;
            drive(tbl[i].valid, tbl[i].data, tbl[i].ex, tbl[i].code);
            jtag_TDO_data = tbl[i].tdo_d; jtag_TDO_driven = tbl[i].tdo_drv;
            cyc();
            chk($sformatf("vec%0d", i), dut_vec(),
                64'({tbl[i].e_ready, tbl[i].e_pins, tbl[i].e_tv, tbl[i].e_tb, tbl[i].e_exit}));
        end

        // ---- back-pressure ----
        bp_cmds[0] = 4'b1001; bp_cmds[1] = 4'b0101; bp_cmds[2] = 4'b1101; bp_cmds[3] = 4'b0011;
        do_reset();
        enable = 0; init_done = 1;
        for (int i = 0; i < 4; i++) begin
            drive(1, bp_cmds[i], 0, '0);
            cyc();
        end
        chk("bp_full_ready", 64'(cmd_ready), 64'(0));
        drive(0, 4'h0, 0, '0);
        enable = 1;
        k = 0;
        for (int r = 0; r < 16; r++) begin
            cyc();
            if (r == 2) chk("bp_ready_before_pop", 64'(cmd_ready), 64'(0));
            if (r == 3) chk("bp_ready_after_pop", 64'(cmd_ready), 64'(1));
            if (tdo_valid) begin
                if (k < 4) begin
                    chk("bp_pop_cycle", 64'(r), 64'(k * 4 + 3));
                    chk("bp_pop_pins", 64'({jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn}), 64'(bp_cmds[k]));
                end
                k++;
            end
        end
        chk("bp_pop_count", 64'(k), 64'(4));

        // ---- gating by init_done ----
        do_reset();
        enable = 1; init_done = 0;
        drive(1, 4'b1010, 0, '0);
        cyc();
        drive(0, 4'h0, 0, '0);
        pulses = 0;
        for (int r = 0; r < 9; r++) begin
            cyc();
            if (tdo_valid) pulses++;
        end
        chk("gate_no_pulse", 64'(pulses), 64'(0));
        chk("gate_pins_idle", 64'({jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn}), 64'(4'b0001));
        init_done = 1;
        first = -1;
        for (int r = 0; r < 6; r++) begin
            cyc();
            if (tdo_valid && first < 0) first = r;
        end
        chk("gate_first_tick", 64'(first), 64'(TD - 1));
        chk("gate_pins", 64'({jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn}), 64'(4'b1010));

        // ---- reset mid-stream ----
        do_reset();
        enable = 0; init_done = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'b1100 | 4'(i), 0, '0);
            cyc();
        end
        drive(0, 4'h0, 0, '0);
        enable = 1;
        cyc(); cyc();
        reset = 1;
        cyc();
        reset = 0;
        chk("mid_rst_state", dut_vec(), 64'({1'b1, 4'b0001, 1'b0, 1'b0, 32'd0}));
        drive(1, 4'b0111, 0, '0);
        first = -1; pulses = 0;
        for (int r = 0; r < 10; r++) begin
            cyc();
            drive(0, 4'h0, 0, '0);
            if (tdo_valid) begin
                pulses++;
                if (first < 0) first = r;
            end
        end
        chk("mid_rst_first_tick", 64'(first), 64'(TD - 1));
        chk("mid_rst_pulses", 64'(pulses), 64'(1));
        chk("mid_rst_pins", 64'({jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn}), 64'(4'b0111));

        // ---- randomized against the model ----
        do_reset();
        for (int r = 0; r < 2000; r++) begin
            reset           = ($urandom_range(0, 199) == 0);
            enable          = ($urandom_range(0, 9) != 0);
            init_done       = ($urandom_range(0, 19) != 0);
            cmd_valid       = ($urandom_range(0, 2) != 0);
            cmd_data        = 4'($urandom);
            cmd_exit        = ($urandom_range(0, 39) == 0);
            cmd_exit_code   = 31'($urandom);
            jtag_TDO_data   = 1'($urandom);
            jtag_TDO_driven = 1'($urandom);
            cyc();
        end
        reset = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
